// File: rtl/decode_pkg.sv
// Shared decode definitions: format codes, major opcode classes (instr[6:2])
// and the decoded-entry record stored in the decode stage output buffer.
package decode_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_R4   = 3'd6,
      FMT_NONE = 3'd7
   } fmt_e;

   localparam logic [4:0] LOAD      = 5'd0;
   localparam logic [4:0] LOAD_FP   = 5'd1;
   localparam logic [4:0] MISC_MEM  = 5'd3;
   localparam logic [4:0] OP_IMM    = 5'd4;
   localparam logic [4:0] AUIPC     = 5'd5;
   localparam logic [4:0] OP_IMM_32 = 5'd6;
   localparam logic [4:0] STORE     = 5'd8;
   localparam logic [4:0] STORE_FP  = 5'd9;
   localparam logic [4:0] AMO       = 5'd11;
   localparam logic [4:0] OP        = 5'd12;
   localparam logic [4:0] LUI       = 5'd13;
   localparam logic [4:0] OP_32     = 5'd14;
   localparam logic [4:0] MADD      = 5'd16;
   localparam logic [4:0] MSUB      = 5'd17;
   localparam logic [4:0] NMSUB     = 5'd18;
   localparam logic [4:0] NMADD     = 5'd19;
   localparam logic [4:0] OP_FP     = 5'd20;
   localparam logic [4:0] BRANCH    = 5'd24;
   localparam logic [4:0] JALR      = 5'd25;
   localparam logic [4:0] JAL       = 5'd27;
   localparam logic [4:0] SYSTEM    = 5'd28;

   // Immediate is kept at the widest legal XLEN; the stage truncates it.
   localparam int IMM_W = 64;

   typedef struct packed {
      fmt_e             fmt;
      logic [4:0]       typ;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rs3;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [IMM_W-1:0] imm;
      logic             illegal;
   } dec_entry_t;

endpackage

// File: rtl/instr_field_decode.sv
// Pure combinational RISC-V field extraction, format classification and
// sign-extended immediate generation.
module instr_field_decode
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0] instr,
   output dec_entry_t  dec
);

   fmt_e             fmt;
   logic [IMM_W-1:0] imm;
   logic             ill;
   logic [4:0]       typ;

   assign typ = instr[6:2];

   always_comb begin
      fmt = FMT_NONE;
      case (typ)
         LOAD, LOAD_FP, MISC_MEM, OP_IMM, OP_IMM_32, JALR, SYSTEM: fmt = FMT_I;
         STORE, STORE_FP:                                         fmt = FMT_S;
         BRANCH:                                                  fmt = FMT_B;
         LUI, AUIPC:                                              fmt = FMT_U;
         JAL:                                                     fmt = FMT_J;
         OP, OP_32, AMO, OP_FP:                                   fmt = FMT_R;
         MADD, MSUB, NMSUB, NMADD:                                fmt = FMT_R4;
         default:                                                 fmt = FMT_NONE;
      endcase
   end

   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
         FMT_J:   imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   // The 32-bit-word opcode classes only exist on RV64.
   assign ill = (instr[1:0] != 2'b11) || (fmt == FMT_NONE) ||
                ((XLEN == 32) && ((typ == OP_IMM_32) || (typ == OP_32)));

   always_comb begin
      dec         = '0;
      dec.fmt     = ill ? FMT_NONE : fmt;
      dec.typ     = typ;
      dec.rd      = instr[11:7];
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rs3     = instr[31:27];
      dec.funct3  = instr[14:12];
      dec.funct7  = instr[31:25];
      dec.imm     = ill ? '0 : imm;
      dec.illegal = ill;
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decoded instructions queue in a BUF_DEPTH FIFO with
// valid/ready on both sides. Optional sticky halt: DECODE_HALT_ON_ILLEGAL_EN.
module instr_decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [2:0]      out_format,
   output logic [4:0]      out_type,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rs3,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);

   dec_entry_t      dec;
   dec_entry_t      mem   [BUF_DEPTH];
   logic [XLEN-1:0] pcm   [BUF_DEPTH];
   dec_entry_t      hd;
   logic [PW-1:0]   wptr, rptr;
   logic [CW-1:0]   count;
   logic            halt;
   logic            push, pop;

   instr_field_decode #(.XLEN(XLEN)) u_dec (.instr(in_instr), .dec(dec));

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (32'(p) == BUF_DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = (32'(count) < BUF_DEPTH) && !halt;
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= nxt(wptr);
         if (pop)  rptr <= nxt(rptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wptr] <= dec;
         pcm[wptr] <= in_pc;
      end
   end

`ifdef DECODE_HALT_ON_ILLEGAL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        halt <= 1'b0;
      else if (flush)                 halt <= 1'b0;
      else if (push && dec.illegal)   halt <= 1'b1;
   end
`else
   assign halt = 1'b0;
`endif

   assign hd          = mem[rptr];
   assign out_pc      = out_valid ? pcm[rptr] : '0;
   assign out_format  = out_valid ? hd.fmt : 3'd0;
   assign out_type    = out_valid ? hd.typ : '0;
   assign out_rd      = out_valid ? hd.rd : '0;
   assign out_rs1     = out_valid ? hd.rs1 : '0;
   assign out_rs2     = out_valid ? hd.rs2 : '0;
   assign out_rs3     = out_valid ? hd.rs3 : '0;
   assign out_funct3  = out_valid ? hd.funct3 : '0;
   assign out_funct7  = out_valid ? hd.funct7 : '0;
   assign out_imm     = out_valid ? hd.imm[XLEN-1:0] : '0;
   assign out_illegal = out_valid ? hd.illegal : 1'b0;

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Registered RISC-V decode stage, successor to the combinational opcode classifier. Decodes the full 32-bit instruction into format, type, register indices, function fields, sign-extended immediate and an illegal flag. Parametrised in XLEN and output-buffer depth, with valid/ready handshakes and flush. Sits between fetch and register-read/execute.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Immediate and PC width follow XLEN.
BUF_DEPTH, 2, output FIFO entries; power of two, at least 1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  discard all buffered entries and any same-cycle input
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes the head entry
out_pc  out  XLEN  PC of the head entry
out_format  out  3  R=0 I=1 S=2 B=3 U=4 J=5 R4=6 NONE=7
out_type  out  5  major opcode class, equal to instr[6:2] (LOAD=0 ... SYSTEM=28)
out_rd, out_rs1, out_rs2, out_rs3  out  5 each  instr[11:7], [19:15], [24:20], [31:27]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  immediate for the format, sign-extended from instr[31]; 0 for R/R4/NONE
out_illegal  out  1  entry is not a valid base opcode

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high. Reset clears the FIFO (count=0, pointers=0) and any halt state. Reset values: out_valid=0, in_ready=1, every data output 0. Reset mid-transfer discards all entries.
- Decode is combinational on in_instr. The result is written to the FIFO on accept (in_valid & in_ready). Latency is 1 cycle: the earliest out_valid is the cycle after accept.
- in_ready = (count < BUF_DEPTH). There is no full-pass-through: when full, in_ready=0 even if out_ready=1.
- Pop occurs when out_valid & out_ready. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo BUF_DEPTH.
- Outputs show the head entry and stay stable while out_valid & !out_ready.
- flush has priority over push and pop. On the next edge, count=0 and the same-cycle input is dropped. in_ready=1 and out_valid=0 the cycle after.
- Format map by type:
  - LOAD, LOAD_FP, MISC_MEM, OP_IMM, OP_IMM_32, JALR, SYSTEM -> I
  - STORE, STORE_FP -> S
  - BRANCH -> B
  - LUI, AUIPC -> U
  - JAL -> J
  - OP, OP_32, AMO, OP_FP -> R
  - MADD, MSUB, NMSUB, NMADD -> R4
  - reserved types 7, 15, 21, 22, 23, 26, 29, 30, 31 -> NONE
- Immediates: I {20{i31}, i[31:20]}; S i[31:25]:i[11:7]; B i[31],i[7],i[30:25],i[11:8],0; U i[31:12]:12'b0; J i[31],i[19:12],i[20],i[30:21],0. All are sign-extended to XLEN.
- out_illegal=1 in any of these cases:
  - instr[1:0] != 2'b11
  - format is NONE
  - XLEN==32 and type is OP_IMM_32 or OP_32
  When illegal, out_type and fields still reflect the raw bits; out_format=7 and out_imm=0.

Optional Feature:
DECODE_HALT_ON_ILLEGAL_EN
- Defined: accepting an illegal instruction sets a sticky halt bit. in_ready is forced to 0 from the next cycle. Buffered entries, including the illegal one, still drain. Only flush or rst clears halt.
- Undefined: the illegal flag is informational only and flow continues.

Decomposition:
- Shared package decode_pkg holds:
  - format codes (FMT_R .. FMT_NONE)
  - 5-bit type codes (LOAD, LOAD_FP, MISC_MEM, OP_IMM, AUIPC, OP_IMM_32, STORE, STORE_FP, AMO, OP, LUI, OP_32, MADD, MSUB, NMSUB, NMADD, OP_FP, BRANCH, JALR, JAL, SYSTEM)
  - the packed decoded-entry struct
- Sub-module instr_field_decode is the pure combinational decode and immediate generation. The top holds only FIFO, handshake and halt logic.

Test Plan:
- Reset, then accept 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, format=1, type=4, rd=1, rs1=0, imm=5, illegal=0.
- Accept 0xFE112E23 (sw x1,-4(x2)) -> format=2, type=8, rs1=2, rs2=1, imm=0xFFFFFFFC.
- Accept 0x123452B7 (lui x5,0x12345) -> format=4, type=13, rd=5, imm=0x12345000.
- out_ready=0, two accepts at BUF_DEPTH=2 -> in_ready=0. Raise out_ready -> entries pop in order and in_ready returns 1 the cycle after the first pop. Assert flush with both entries full -> out_valid=0 the next cycle.
- 0x0000007F -> illegal=1, format=7. 0x0000003B at XLEN=32 -> illegal=1. The same word at XLEN=64 -> legal, format=0, type=14.
- With DECODE_HALT_ON_ILLEGAL_EN: after 0x0000007F is accepted, in_ready=0 until flush. Assert rst mid-stream -> out_valid=0 and in_ready=1 immediately, asynchronously.
